// File: rtl/simon_pkg.sv
// Shared types for the Simon Says datapath: colour encoding, sequencer states, LED decode.
package simon_pkg;

   typedef logic [1:0] color_t;

   localparam color_t COL_RED    = 2'd0;
   localparam color_t COL_GREEN  = 2'd1;
   localparam color_t COL_BLUE   = 2'd2;
   localparam color_t COL_YELLOW = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_PLAY_ON,
      ST_PLAY_OFF,
      ST_DONE
   } seq_state_t;

   function automatic logic [3:0] onehot4(input color_t c);
      logic [3:0] r;
      case (c)
         COL_RED:    r = 4'b0001;
         COL_GREEN:  r = 4'b0010;
         COL_BLUE:   r = 4'b0100;
         COL_YELLOW: r = 4'b1000;
         default:    r = 4'b0000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/simon_seq_mem.sv
// Colour sequence store: MAX_LEN x 2-bit, synchronous write, two asynchronous read ports.
module simon_seq_mem
   import simon_pkg::*;
#(
   parameter int MAX_LEN = 16,
   parameter int AW      = $clog2(MAX_LEN + 1)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  color_t        wdata,
   input  logic [AW-1:0] raddr_a,
   output color_t        rdata_a,
   input  logic [AW-1:0] raddr_b,
   output color_t        rdata_b
);

   localparam int            IW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [AW-1:0] DEPTH = AW'(MAX_LEN);

   color_t mem_q [MAX_LEN];

   always_ff @(posedge clk) begin
      if (we && (waddr < DEPTH)) mem_q[waddr[IW-1:0]] <= wdata;
   end

   // Out-of-range addresses read as RED rather than aliasing onto a real entry.
   assign rdata_a = (raddr_a < DEPTH) ? mem_q[raddr_a[IW-1:0]] : COL_RED;
   assign rdata_b = (raddr_b < DEPTH) ? mem_q[raddr_b[IW-1:0]] : COL_RED;

endmodule

// File: rtl/simon_sequencer.sv
// Simon Says sequencer: appends one LFSR colour per round, then plays the whole
// sequence out on one-hot LEDs with fixed on/off timing.
module simon_sequencer
   import simon_pkg::*;
#(
   parameter int MAX_LEN    = 16,
   parameter int ON_CYCLES  = 8,
   parameter int OFF_CYCLES = 4,
   parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             new_game,
   input  logic             start_round,
   input  logic [7:0]       lfsr_data,
   input  logic             lfsr_valid,
   input  logic [LEN_W-1:0] rd_idx,
   output color_t           rd_color,
   output logic [3:0]       led,
   output logic [LEN_W-1:0] seq_len,
   output logic             busy,
   output logic             play_done,
   output logic             full
);

   localparam int               TW      = $clog2(ON_CYCLES + OFF_CYCLES + 1);
   localparam logic [TW-1:0]    ON_LAST  = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0]    OFF_LAST = TW'(OFF_CYCLES - 1);
   localparam logic [TW-1:0]    T_ONE    = TW'(1);
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

   seq_state_t       state_q, state_d;
   logic [LEN_W-1:0] seq_len_q, seq_len_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [3:0]       led_q, led_d;
   logic             busy_q, busy_d;
   logic             play_done_q, play_done_d;
   logic             full_q, full_d;

   logic   wr_en;
   color_t mem_rd, play_rd, play_color;

   simon_seq_mem #(.MAX_LEN(MAX_LEN), .AW(LEN_W)) u_mem (
      .clk     (clk),
      .we      (wr_en),
      .waddr   (seq_len_q),
      .wdata   (lfsr_data[1:0]),
      .raddr_a (rd_idx),
      .rdata_a (mem_rd),
      .raddr_b (idx_d),
      .rdata_b (play_rd)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         seq_len_q   <= '0;
         idx_q       <= '0;
         timer_q     <= '0;
         led_q       <= '0;
         busy_q      <= 1'b0;
         play_done_q <= 1'b0;
         full_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         seq_len_q   <= seq_len_d;
         idx_q       <= idx_d;
         timer_q     <= timer_d;
         led_q       <= led_d;
         busy_q      <= busy_d;
         play_done_q <= play_done_d;
         full_q      <= full_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      seq_len_d = seq_len_q;
      idx_d     = idx_q;
      timer_d   = timer_q;
      wr_en     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_round) begin
               idx_d   = '0;
               timer_d = '0;
               state_d = full_q ? ST_PLAY_ON : ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (lfsr_valid) begin
               wr_en = (seq_len_q != LEN_MAX);
               if (seq_len_q != LEN_MAX) seq_len_d = seq_len_q + LEN_ONE;
               idx_d   = '0;
               timer_d = '0;
               state_d = ST_PLAY_ON;
            end
         end
         ST_PLAY_ON: begin
            if (timer_q == ON_LAST) begin
               timer_d = '0;
               state_d = ST_PLAY_OFF;
            end else begin
               timer_d = timer_q + T_ONE;
            end
         end
         ST_PLAY_OFF: begin
            if (timer_q == OFF_LAST) begin
               timer_d = '0;
               if ((idx_q + LEN_ONE) == seq_len_q) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + LEN_ONE;
                  state_d = ST_PLAY_ON;
               end
            end else begin
               timer_d = timer_q + T_ONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (new_game) begin
         state_d   = ST_IDLE;
         seq_len_d = '0;
         idx_d     = '0;
         timer_d   = '0;
         wr_en     = 1'b0;
      end
   end

   // The entry being captured is not in memory yet, so forward it to the LEDs directly.
   always_comb begin
      play_color  = (wr_en && (seq_len_q == idx_d)) ? lfsr_data[1:0] : play_rd;
      led_d       = (state_d == ST_PLAY_ON) ? onehot4(play_color) : 4'b0000;
      busy_d      = (state_d != ST_IDLE);
      play_done_d = (state_d == ST_DONE);
      full_d      = (seq_len_d == LEN_MAX);
   end

   assign rd_color  = (rd_idx < seq_len_q) ? mem_rd : COL_RED;
   assign led       = led_q;
   assign seq_len   = seq_len_q;
   assign busy      = busy_q;
   assign play_done = play_done_q;
   assign full      = full_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench for simon_sequencer: table-driven first round, then modelled rounds and corner cases.
`timescale 1ns/1ps
module tb_simon_sequencer;
   import simon_pkg::*;

   localparam int MAX_LEN = 16;
   localparam int ON      = 8;
   localparam int OFF     = 4;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);

   logic             clk = 1'b0;
   logic             rst, new_game, start_round, lfsr_valid;
   logic [7:0]       lfsr_data;
   logic [LEN_W-1:0] rd_idx;
   color_t           rd_color;
   logic [3:0]       led;
   logic [LEN_W-1:0] seq_len;
   logic             busy, play_done, full;

   simon_sequencer #(.MAX_LEN(MAX_LEN), .ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
      .clk         (clk),
      .rst         (rst),
      .new_game    (new_game),
      .start_round (start_round),
      .lfsr_data   (lfsr_data),
      .lfsr_valid  (lfsr_valid),
      .rd_idx      (rd_idx),
      .rd_color    (rd_color),
      .led         (led),
      .seq_len     (seq_len),
      .busy        (busy),
      .play_done   (play_done),
      .full        (full)
   );

   always #5 clk = ~clk;

   int     n_chk = 0, n_fail = 0, cyc = 0;
   color_t exp_seq [MAX_LEN];
   int     exp_len = 0;

   typedef struct {
      int         c_lo, c_hi;
      logic       st, vl;
      logic [7:0] dat;
      logic [3:0] e_led;
      logic       e_busy, e_done;
      int         e_len;
   } vec_t;
   vec_t tbl [7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic logic [3:0] oh(input color_t c);
      logic [3:0] r;
      r = 4'b0001 << c;
      return r;
   endfunction

   // Only called while idle: the extra #1 delays cannot disturb a playback in flight.
   task automatic chk_mem();
      for (int i = 0; i < exp_len; i++) begin
         rd_idx = LEN_W'(i);
         #1;
         chk("rd_color", rd_color, exp_seq[i]);
      end
      rd_idx = LEN_W'(exp_len);
      #1;
      chk("rd_color_past_len", rd_color, 0);
      rd_idx = '0;
   endtask

   task automatic do_round(input logic [7:0] data, input bit replay, input int stall,
                           input bit poke_start, input bit poke_done);
      start_round = 1'b1;
      step();
      start_round = 1'b0;
      if (!replay) begin
         for (int s = 0; s < stall; s++) begin
            chk("cap_busy", busy, 1);
            chk("cap_led", led, 0);
            step();
         end
         lfsr_valid = 1'b1;
         lfsr_data  = data;
         step();
         lfsr_valid = 1'b0;
         if (exp_len < MAX_LEN) begin
            exp_seq[exp_len] = data[1:0];
            exp_len++;
         end
      end
      chk("seq_len", seq_len, exp_len);
      chk("full", full, (exp_len == MAX_LEN));
      for (int i = 0; i < exp_len; i++) begin
         for (int j = 0; j < ON; j++) begin
            chk("led_on", led, oh(exp_seq[i]));
            chk("busy_on", busy, 1);
            chk("done_on", play_done, 0);
            if (poke_start && i == 0 && j == 2) start_round = 1'b1;
            step();
            start_round = 1'b0;
         end
         for (int j = 0; j < OFF; j++) begin
            chk("led_off", led, 0);
            chk("busy_off", busy, 1);
            chk("done_off", play_done, 0);
            step();
         end
      end
      chk("done_pulse", play_done, 1);
      chk("done_busy", busy, 1);
      chk("done_led", led, 0);
      if (poke_done) begin
         lfsr_valid = 1'b1;
         lfsr_data  = 8'hFF;
      end
      step();
      lfsr_valid = 1'b0;
      chk("after_done", play_done, 0);
      chk("after_busy", busy, 0);
      chk("after_led", led, 0);
      chk("after_len", seq_len, exp_len);
   endtask

   initial begin
      bit seen_done;
      rst = 1'b1; new_game = 1'b0; start_round = 1'b0; lfsr_valid = 1'b0;
      lfsr_data = 8'h00; rd_idx = '0;

      tbl[0] = '{0,  0,  1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 0};
      tbl[1] = '{1,  2,  1'b0, 1'b0, 8'h00, 4'b0000, 1'b1, 1'b0, 0};
      tbl[2] = '{3,  3,  1'b0, 1'b1, 8'hA6, 4'b0000, 1'b1, 1'b0, 0};
      tbl[3] = '{4,  11, 1'b0, 1'b0, 8'h00, 4'b0100, 1'b1, 1'b0, 1};
      tbl[4] = '{12, 15, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b1, 1'b0, 1};
      tbl[5] = '{16, 16, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b1, 1'b1, 1};
      tbl[6] = '{17, 17, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 1};

      repeat (3) step();
      rst = 1'b0;
      step();
      cyc = 0;
      chk("rst_full", full, 0);

      // Round 1: start at cycle 0, lfsr_valid with 8'hA6 at cycle 3.
      for (int c = 0; c <= 17; c++) begin
         for (int k = 0; k < 7; k++) begin
            if (c >= tbl[k].c_lo && c <= tbl[k].c_hi) begin
               chk("t_led", led, tbl[k].e_led);
               chk("t_busy", busy, tbl[k].e_busy);
               chk("t_done", play_done, tbl[k].e_done);
               chk("t_len", seq_len, tbl[k].e_len);
               start_round = tbl[k].st;
               lfsr_valid  = tbl[k].vl;
               lfsr_data   = tbl[k].dat;
            end
         end
         step();
      end
      start_round = 1'b0; lfsr_valid = 1'b0;
      exp_seq[0] = COL_BLUE;
      exp_len    = 1;
      chk_mem();

      // Round 2: BLUE then GREEN, 24 playback cycles.
      do_round(8'h01, 1'b0, 0, 1'b0, 1'b0);
      chk_mem();

      // Round 3: stalled capture, start_round during playback, lfsr_valid in DONE.
      do_round(8'h07, 1'b0, 2, 1'b1, 1'b1);
      chk_mem();

      // lfsr_valid while idle must not write or grow the sequence.
      lfsr_valid = 1'b1; lfsr_data = 8'h02;
      step();
      lfsr_valid = 1'b0;
      step();
      chk("idle_valid_len", seq_len, exp_len);
      chk("idle_valid_busy", busy, 0);
      chk_mem();

      // new_game while idle clears the sequence.
      new_game = 1'b1;
      step();
      new_game = 1'b0;
      exp_len = 0;
      chk("ng_len", seq_len, 0);
      do_round(8'h00, 1'b0, 1, 1'b0, 1'b0);
      do_round(8'h02, 1'b0, 0, 1'b0, 1'b0);

      // Third round aborted during PLAY_ON of colour 2 of 3.
      start_round = 1'b1;
      step();
      start_round = 1'b0;
      lfsr_valid = 1'b1; lfsr_data = 8'h05;
      step();
      lfsr_valid = 1'b0;
      exp_seq[2] = COL_GREEN;
      repeat (ON + OFF + 3) step();
      chk("abort_pre_led", led, oh(exp_seq[1]));
      new_game = 1'b1;
      step();
      new_game = 1'b0;
      exp_len = 0;
      chk("abort_busy", busy, 0);
      chk("abort_led", led, 0);
      chk("abort_len", seq_len, 0);
      chk("abort_done", play_done, 0);
      seen_done = 1'b0;
      for (int i = 0; i < 3 * (ON + OFF) + 4; i++) begin
         if (play_done) seen_done = 1'b1;
         step();
      end
      chk("abort_no_done", seen_done, 0);
      chk("abort_idle_busy", busy, 0);

      // start_round coincident with new_game is dropped.
      new_game = 1'b1; start_round = 1'b1;
      step();
      new_game = 1'b0; start_round = 1'b0;
      chk("ng_start_busy", busy, 0);
      step();
      chk("ng_start_busy2", busy, 0);

      // Fill to MAX_LEN.
      for (int r = 0; r < MAX_LEN; r++) begin
         chk("fill_full_pre", full, 0);
         do_round(8'(r * 53 + 7), 1'b0, r % 3, 1'b0, 1'b0);
      end
      chk("full_set", full, 1);
      chk("full_len", seq_len, MAX_LEN);
      chk_mem();

      // 17th round replays without capture; length saturates.
      do_round(8'h00, 1'b1, 0, 1'b0, 1'b0);
      chk("replay_len", seq_len, MAX_LEN);
      chk("replay_full", full, 1);
      chk_mem();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
